// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: the sequencer state encoding,
// the owner encoding used by grantData and the round-robin pointer, and the
// default memory geometry.
package mem_arb_pkg;

   localparam int ADDR_WIDTH_DEF = 11;
   localparam int DATA_WIDTH_DEF = 16;
   localparam int MEM_DEPTH_DEF  = 64;

   // Owner of an access; also the value carried on grantData.
   localparam logic OWNER_FETCH = 1'b0;
   localparam logic OWNER_DATA  = 1'b1;

   // One access walks IDLE -> ISSUE -> CAPTURE -> IDLE.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } arb_state_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_select.sv
// Winner selection for the memory arbiter.
// Tie policy is chosen by MEM_ARB_ROUND_ROBIN_EN:
//   defined   - ties go to the port not served most recently; a 1-bit
//               last-grant register is updated on every CAPTURE and resets
//               to "fetch served last", so the first tie goes to data.
//   undefined - fixed priority, the data port always wins ties.
// A single active request always wins regardless of the policy.
module mem_arb_select
   import mem_arb_pkg::*;
(
   input  logic clock,
   input  logic resetN,
   input  logic fetch_req,
   input  logic data_req,
   input  logic update_en,     // high during CAPTURE of an access
   input  logic served_owner,  // owner of the access being completed
   output logic winner         // owner of the next access, valid when a req is high
);

`ifdef MEM_ARB_ROUND_ROBIN_EN

   logic last_grant_q;
   logic last_grant_d;

   // Remember which port completed the most recent access.
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
      last_grant_d = last_grant_q;
      if (update_en) begin
         last_grant_d = served_owner;
      end
   end

   // Last-grant register; reset means fetch was served last.
   always_ff @(posedge clock) begin
      // NOTE: reset is synchronous here: it is only seen at a rising edge, like any other input.
      if (!resetN) begin
         // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
         last_grant_q <= OWNER_FETCH;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   // Single request wins; a tie goes to the port that did not go last.
   always_comb begin
      winner = OWNER_FETCH;
      if (fetch_req && data_req) begin
         winner = (last_grant_q == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
      end else if (data_req) begin
         winner = OWNER_DATA;
      end
   end

`else

   // Fixed priority keeps no history; these inputs only matter for round robin.
   logic unused_rr_inputs;
   assign unused_rr_inputs = ^{clock, resetN, update_en, served_owner, fetch_req};

   // Data port wins whenever it asks.
   always_comb begin
      winner = OWNER_FETCH;
      if (data_req) begin
         winner = OWNER_DATA;
      end
   end

`endif

endmodule : mem_arb_select

// File: rtl/memory_arbiter.sv
// Shares a single-port, synchronous-read memory between the instruction
// fetch port and the load/store port. Each access takes three cycles:
// IDLE picks a winner and latches its request, ISSUE drives one strobe
// cycle, CAPTURE returns the ack (and read data, since the memory output is
// registered). Out-of-range addresses suppress the strobe and raise
// addrError with the ack; reads of them return 0.
// Tie policy comes from mem_arb_select (macro MEM_ARB_ROUND_ROBIN_EN).
module memory_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int MEM_DEPTH  = MEM_DEPTH_DEF
) (
   input  logic                  clock,
   input  logic                  resetN,
   // instruction fetch port
   input  logic                  fetchReq,
   input  logic [ADDR_WIDTH-1:0] fetchAddr,
   output logic                  fetchAck,
   output logic [DATA_WIDTH-1:0] fetchData,
   // load/store port
   input  logic                  dataReq,
   input  logic                  dataWrite,
   input  logic [ADDR_WIDTH-1:0] dataAddr,
   input  logic [DATA_WIDTH-1:0] dataWdata,
   output logic                  dataAck,
   output logic [DATA_WIDTH-1:0] dataRdata,
   // memory side
   output logic [ADDR_WIDTH-1:0] memAddress,
   output logic [DATA_WIDTH-1:0] memDataIn,
   output logic                  memRead,
   output logic                  memWrite,
   input  logic [DATA_WIDTH-1:0] memDataOut,
   // status
   output logic                  busy,
   output logic                  grantData,
   output logic                  addrError
);

   // One extra bit so MEM_DEPTH equal to 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   arb_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  write_q, write_d;
   logic                  grant_q, grant_d;
   logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
   logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

   logic                  winner;
   logic                  any_req;
   logic                  out_of_range;
   logic                  capture_read;
   logic [DATA_WIDTH-1:0] read_word;

   assign any_req      = fetchReq | dataReq;
   assign out_of_range = {1'b0, addr_q} >= DEPTH_LIMIT;
   assign capture_read = (state_q == CAPTURE) && !write_q;
   assign read_word    = out_of_range ? '0 : memDataOut;

   mem_arb_select u_select (
      .clock        (clock),
      .resetN       (resetN),
      .fetch_req    (fetchReq),
      .data_req     (dataReq),
      .update_en    (state_q == CAPTURE),
      .served_owner (grant_q),
      .winner       (winner)
   );

   // Sequencer next state: latch the winner in IDLE, load read data in CAPTURE.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      write_d      = write_q;
      grant_d      = grant_q;
      fetch_data_d = fetch_data_q;
      data_rdata_d = data_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = winner;
               if (winner == OWNER_DATA) begin
                  addr_d  = dataAddr;
                  wdata_d = dataWdata;
                  write_d = dataWrite;
               end else begin
                  addr_d  = fetchAddr;
                  write_d = 1'b0;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            if (capture_read) begin
               if (grant_q == OWNER_DATA) begin
                  data_rdata_d = read_word;
               end else begin
                  fetch_data_d = read_word;
               end
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer registers; reset abandons any access in flight without an ack.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         grant_q      <= OWNER_FETCH;
         fetch_data_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         write_q      <= write_d;
         grant_q      <= grant_d;
         fetch_data_q <= fetch_data_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   // Strobes only in ISSUE for in-range addresses; acks and addrError only in CAPTURE.
   always_comb begin
      memRead   = 1'b0;
      memWrite  = 1'b0;
      fetchAck  = 1'b0;
      dataAck   = 1'b0;
      addrError = 1'b0;
      if ((state_q == ISSUE) && !out_of_range) begin
         memRead  = !write_q;
         memWrite = write_q;
      end
      if (state_q == CAPTURE) begin
         fetchAck  = (grant_q == OWNER_FETCH);
         dataAck   = (grant_q == OWNER_DATA);
         addrError = out_of_range;
      end
   end

   // Read data is visible in the ack cycle and then held until the next read.
   assign fetchData  = fetch_data_d;
   assign dataRdata  = data_rdata_d;
   assign memAddress = addr_q;
   assign memDataIn  = wdata_q;
   assign busy       = (state_q != IDLE);
   assign grantData  = grant_q;

endmodule : memory_arbiter

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter. A synchronous-read memory model
// sits on the memory side. Each transaction issued by a driver pushes its
// expected ack result and expected strobe into per-port queues; a monitor
// on the falling edge pops and compares whenever an ack or strobe appears.
`timescale 1ns/1ps
module tb_memory_arbiter;
   import mem_arb_pkg::*;

   localparam int AW    = 11;
   localparam int DW    = 16;
   localparam int DEPTH = 64;

   logic          clock = 1'b0;
   logic          resetN;
   logic          fetchReq, dataReq, dataWrite;
   logic [AW-1:0] fetchAddr, dataAddr;
   logic [DW-1:0] dataWdata;
   logic          fetchAck, dataAck;
   logic [DW-1:0] fetchData, dataRdata;
   logic [AW-1:0] memAddress;
   logic [DW-1:0] memDataIn, memDataOut;
   logic          memRead, memWrite, busy, grantData, addrError;

   always #5 clock = ~clock;

   memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
      .clock      (clock),
      .resetN     (resetN),
      .fetchReq   (fetchReq),
      .fetchAddr  (fetchAddr),
      .fetchAck   (fetchAck),
      .fetchData  (fetchData),
      .dataReq    (dataReq),
      .dataWrite  (dataWrite),
      .dataAddr   (dataAddr),
      .dataWdata  (dataWdata),
      .dataAck    (dataAck),
      .dataRdata  (dataRdata),
      .memAddress (memAddress),
      .memDataIn  (memDataIn),
      .memRead    (memRead),
      .memWrite   (memWrite),
      .memDataOut (memDataOut),
      .busy       (busy),
      .grantData  (grantData),
      .addrError  (addrError)
   );

   // Environment memory: registered read, write on strobe.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clock) begin
      if (memRead)  memDataOut <= mem[memAddress[5:0]];
      if (memWrite) mem[memAddress[5:0]] <= memDataIn;
   end

   // Reference model state
   typedef struct {
      logic          is_read;
      logic [DW-1:0] data;
      logic          err;
   } ack_exp_t;

   typedef struct {
      logic          is_write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } strobe_exp_t;

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_fetch_last, exp_data_last;
   ack_exp_t      fetch_q[$], data_q[$];
   strobe_exp_t   fstrobe_q[$], dstrobe_q[$];

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Predict the outcome of one access from the port rules.
   task automatic model_issue(input logic is_data, input logic wr,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      ack_exp_t    a;
      strobe_exp_t s;
      bit          in_range;
      in_range   = (int'(addr) < DEPTH);
      a.err      = !in_range;
      a.is_read  = !wr;
      s.is_write = wr;
      s.addr     = addr;
      s.wdata    = wdata;
      if (wr) begin
         a.data = is_data ? exp_data_last : exp_fetch_last;
         if (in_range) ref_mem[addr[5:0]] = wdata;
      end else begin
         a.data = in_range ? ref_mem[addr[5:0]] : '0;
         if (is_data) exp_data_last = a.data;
         else         exp_fetch_last = a.data;
      end
      if (is_data) begin
         data_q.push_back(a);
         if (in_range) dstrobe_q.push_back(s);
      end else begin
         fetch_q.push_back(a);
         if (in_range) fstrobe_q.push_back(s);
      end
   endtask

   // Monitor: compare acks and strobes against the queues.
   ack_exp_t    mon_a;
   strobe_exp_t mon_s;
   always @(negedge clock) begin
      if (fetchAck && dataAck) check("acks_exclusive", 32'(fetchAck & dataAck), 32'd0);
      if (fetchAck) begin
         check("fetch_ack_expected", 32'(fetch_q.size() > 0), 32'd1);
         if (fetch_q.size() > 0) begin
            mon_a = fetch_q.pop_front();
            check("fetch_addr_error", 32'(addrError), 32'(mon_a.err));
            check("fetch_data", 32'(fetchData), 32'(mon_a.data));
         end
      end
      if (dataAck) begin
         check("data_ack_expected", 32'(data_q.size() > 0), 32'd1);
         if (data_q.size() > 0) begin
            mon_a = data_q.pop_front();
            check("data_addr_error", 32'(addrError), 32'(mon_a.err));
            check("data_rdata", 32'(dataRdata), 32'(mon_a.data));
         end
      end
      if (addrError && !fetchAck && !dataAck) check("addr_error_without_ack", 32'(addrError), 32'd0);
      if (memRead || memWrite) begin
         check("strobes_exclusive", 32'(memRead & memWrite), 32'd0);
         if (grantData) begin
            check("data_strobe_expected", 32'(dstrobe_q.size() > 0), 32'd1);
            if (dstrobe_q.size() > 0) mon_s = dstrobe_q.pop_front();
         end else begin
            check("fetch_strobe_expected", 32'(fstrobe_q.size() > 0), 32'd1);
            if (fstrobe_q.size() > 0) mon_s = fstrobe_q.pop_front();
         end
         check("strobe_dir", 32'(memWrite), 32'(mon_s.is_write));
         check("strobe_addr", 32'(memAddress), 32'(mon_s.addr));
         if (memWrite) check("strobe_wdata", 32'(memDataIn), 32'(mon_s.wdata));
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 10) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic wait_ack(input logic is_data, input bit check_lat);
      int   lat   = 0;
      logic acked = 1'b0;
      while (!acked && lat < 60) begin
         @(negedge clock);
         lat++;
         acked = is_data ? dataAck : fetchAck;
      end
      check(is_data ? "data_ack_seen" : "fetch_ack_seen", 32'(acked), 32'd1);
      if (check_lat) check("ack_latency", 32'(lat), 32'd2);
   endtask

   // One complete access; the request drops in the ack cycle.
   task automatic port_txn(input logic is_data, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input bit check_lat);
      if (check_lat) wait_idle();
      model_issue(is_data, wr, addr, wdata);
      if (is_data) begin
         dataAddr  = addr;
         dataWrite = wr;
         dataWdata = wdata;
         dataReq   = 1'b1;
      end else begin
         fetchAddr = addr;
         fetchReq  = 1'b1;
      end
      wait_ack(is_data, check_lat);
      if (is_data) dataReq = 1'b0;
      else         fetchReq = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic order [4];
      int   n_acks;
      int   cyc;

      fetchReq = 0; dataReq = 0; dataWrite = 0;
      fetchAddr = '0; dataAddr = '0; dataWdata = '0;
      resetN = 1'b0;
      exp_fetch_last = '0;
      exp_data_last  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 16'(i * 257 + 4096);
         ref_mem[i] = 16'(i * 257 + 4096);
      end
      mem[10] = 16'h0009; ref_mem[10] = 16'h0009;
      mem[11] = 16'hFFF4; ref_mem[11] = 16'hFFF4;

      repeat (3) @(negedge clock);
      check("rst_busy",       32'(busy), 32'd0);
      check("rst_memRead",    32'(memRead), 32'd0);
      check("rst_memWrite",   32'(memWrite), 32'd0);
      check("rst_fetchAck",   32'(fetchAck), 32'd0);
      check("rst_dataAck",    32'(dataAck), 32'd0);
      check("rst_addrError",  32'(addrError), 32'd0);
      check("rst_grantData",  32'(grantData), 32'd0);
      check("rst_memAddress", 32'(memAddress), 32'd0);
      check("rst_memDataIn",  32'(memDataIn), 32'd0);
      check("rst_fetchData",  32'(fetchData), 32'd0);
      check("rst_dataRdata",  32'(dataRdata), 32'd0);
      resetN = 1'b1;
      @(negedge clock);

      // Fetch of word 10, then the result holds.
      port_txn(1'b0, 1'b0, 11'd10, '0, 1'b1);
      @(negedge clock);
      check("fetchData_hold", 32'(fetchData), 32'h0009);

      // Data write then read-back of address 12.
      port_txn(1'b1, 1'b1, 11'd12, 16'hABCD, 1'b1);
      port_txn(1'b1, 1'b0, 11'd12, '0, 1'b1);

      // Out-of-range read.
      port_txn(1'b1, 1'b0, 11'd100, '0, 1'b1);

      // Reset in ISSUE: the interrupted read still strobes but never acks.
      wait_idle();
      fstrobe_q.push_back('{is_write: 1'b0, addr: 11'd10, wdata: '0});
      fetchAddr = 11'd10;
      fetchReq  = 1'b1;
      @(negedge clock);
      check("busy_in_issue", 32'(busy), 32'd1);
      resetN = 1'b0;
      @(negedge clock);
      check("rst_mid_busy",      32'(busy), 32'd0);
      check("rst_mid_memRead",   32'(memRead), 32'd0);
      check("rst_mid_fetchAck",  32'(fetchAck), 32'd0);
      check("rst_mid_fetchData", 32'(fetchData), 32'd0);
      exp_fetch_last = '0;
      exp_data_last  = '0;
      model_issue(1'b0, 1'b0, 11'd10, '0);
      resetN = 1'b1;
      wait_ack(1'b0, 1'b1);
      fetchReq = 1'b0;

      // Both requests held continuously.
`ifdef MEM_ARB_ROUND_ROBIN_EN
      order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      wait_idle();
      for (int k = 0; k < 4; k++) model_issue(order[k], 1'b0, order[k] ? 11'd10 : 11'd11, '0);
      fetchAddr = 11'd11;
      dataAddr  = 11'd10;
      dataWrite = 1'b0;
      fetchReq  = 1'b1;
      dataReq   = 1'b1;
      n_acks = 0;
      cyc    = 0;
      while (n_acks < 4 && cyc < 40) begin
         @(negedge clock);
         cyc++;
         if (fetchAck || dataAck) begin
            check("tie_owner", 32'(dataAck), 32'(order[n_acks]));
            check("tie_ack_spacing", 32'(cyc), 32'(2 + 3 * n_acks));
            n_acks++;
         end
      end
      check("tie_acks_seen", 32'(n_acks), 32'd4);
      fetchReq = 1'b0;
      dataReq  = 1'b0;

      // Randomised traffic: fetch reads a region the data port never writes.
      wait_idle();
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               logic [AW-1:0] a;
               a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(64, 2047))
                                               : AW'($urandom_range(0, 31));
               port_txn(1'b0, 1'b0, a, '0, 1'b0);
               repeat ($urandom_range(2, 5)) @(negedge clock);
            end
         end
         begin
            for (int i = 0; i < 60; i++) begin
               logic [AW-1:0] a;
               logic          wr;
               a  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(64, 2047))
                                                : AW'($urandom_range(32, 63));
               wr = 1'($urandom_range(0, 1));
               port_txn(1'b1, wr, a, DW'($urandom), 1'b0);
               repeat ($urandom_range(2, 5)) @(negedge clock);
            end
         end
      join

      repeat (4) @(negedge clock);
      check("fetch_queue_drained",  32'(fetch_q.size()), 32'd0);
      check("data_queue_drained",   32'(data_q.size()), 32'd0);
      check("fstrobe_queue_drained", 32'(fstrobe_q.size()), 32'd0);
      check("dstrobe_queue_drained", 32'(dstrobe_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_memory_arbiter
